// File: rtl/avg_iq_accum.sv
// avg_iq_accum: averages 2^log2n complex samples of one selected channel
// from a channelizer stream. A software start edge arms the block, the next
// frame sync begins accumulation, and the mean is presented with a one-cycle
// avg_valid pulse. busy/done mirror the FSM for register readback.
module avg_iq_accum #(
  parameter int DATA_W   = 16,
  parameter int CHAN_W   = 8,
  parameter int MAX_LOG2 = 12
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [31:0]              ctrl,
  input  logic                     sync_in,
  input  logic                     iq_valid,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  output logic signed [DATA_W-1:0] avg_i,
  output logic signed [DATA_W-1:0] avg_q,
  output logic                     avg_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [3:0] MAX_L2 = 4'(MAX_LOG2);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DONE} state_t;

  state_t                    state_reg;
  logic                      start_prev_reg;
  logic [3:0]                log2n_reg;
  logic [CHAN_W-1:0]         chan_sel_reg;
  logic [CHAN_W-1:0]         chan_cnt_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic signed [ACC_W-1:0]   acc_i_reg;
  logic signed [ACC_W-1:0]   acc_q_reg;

  // Control word decode
  logic                      start_edge;
  logic                      abort;
  logic [3:0]                log2n_req;
  logic [3:0]                log2n_clamped;
  logic [CHAN_W-1:0]         chan_req;

  assign start_edge    = ctrl[0] & ~start_prev_reg;
  assign abort         = ctrl[1];
  assign log2n_req     = ctrl[5:2];
  assign log2n_clamped = (log2n_req > MAX_L2) ? MAX_L2 : log2n_req;
  assign chan_req      = ctrl[8 +: CHAN_W];

  // Bits of the control word this block does not interpret
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[31:8+CHAN_W], ctrl[7:6]};

  // Datapath: channel of the current sample, accumulate enable, next sums
  logic [CHAN_W-1:0]         cur_chan;
  logic                      take;
  logic                      last;
  logic [CNT_W-1:0]          cnt_next;
  logic [CNT_W-1:0]          target;
  logic signed [ACC_W-1:0]   acc_i_next;
  logic signed [ACC_W-1:0]   acc_q_next;
  logic signed [ACC_W-1:0]   mean_i;
  logic signed [ACC_W-1:0]   mean_q;

  // A sync-qualified sample is always channel 0, regardless of the counter
  assign cur_chan = sync_in ? '0 : chan_cnt_reg;

  // In ARM only the frame-start sample can be taken; in ACCUM any matching channel
  assign take = iq_valid &&
                (((state_reg == ARM) && sync_in && (chan_sel_reg == '0)) ||
                 ((state_reg == ACCUM) && (cur_chan == chan_sel_reg)));

  assign cnt_next   = cnt_reg + CNT_W'(1);
  assign target     = CNT_W'(1) << log2n_reg;
  assign last       = take && (cnt_next == target);

  assign acc_i_next = acc_i_reg + {{MAX_LOG2{i_in[DATA_W-1]}}, i_in};
  assign acc_q_next = acc_q_reg + {{MAX_LOG2{q_in[DATA_W-1]}}, q_in};

  // Arithmetic shift floors toward -inf; the mean always fits in DATA_W bits
  assign mean_i     = acc_i_next >>> log2n_reg;
  assign mean_q     = acc_q_next >>> log2n_reg;

  // Channel counter tracks the position of each valid sample within a frame
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      chan_cnt_reg <= '0;
    end else if (iq_valid) begin
      if (sync_in) chan_cnt_reg <= CHAN_W'(1);
      else         chan_cnt_reg <= chan_cnt_reg + CHAN_W'(1);
    end
  end

  // Control FSM, accumulators and registered outputs
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b1;
      log2n_reg      <= '0;
      chan_sel_reg   <= '0;
      cnt_reg        <= '0;
      acc_i_reg      <= '0;
      acc_q_reg      <= '0;
      avg_i          <= '0;
      avg_q          <= '0;
      avg_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // Edge detector always tracks ctrl[0] so a start seen during abort is consumed
      start_prev_reg <= ctrl[0];
      avg_valid      <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        acc_i_reg <= '0;
        acc_q_reg <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            if (start_edge) begin
              state_reg    <= ARM;
              log2n_reg    <= log2n_clamped;
              chan_sel_reg <= chan_req;
              cnt_reg      <= '0;
              acc_i_reg    <= '0;
              acc_q_reg    <= '0;
              busy         <= 1'b1;
              done         <= 1'b0;
            end
          end
          ARM, ACCUM: begin
            if ((state_reg == ARM) && iq_valid && sync_in) state_reg <= ACCUM;
            if (take) begin
              acc_i_reg <= acc_i_next;
              acc_q_reg <= acc_q_next;
              cnt_reg   <= cnt_next;
              if (last) begin
                state_reg <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                avg_i     <= mean_i[DATA_W-1:0];
                avg_q     <= mean_q[DATA_W-1:0];
                avg_valid <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
